// File: rtl/cmp_result_filter.sv
// Debounces the comparator's one-hot relation flags into a filtered relation,
// pulsing on each accepted change and counting entries per relation.
module cmp_result_filter #(
  parameter int unsigned DEBOUNCE = 3,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             equal,
  input  logic             greater,
  input  logic             lower,
  input  logic             clear,
  output logic [1:0]       state,
  output logic             change,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic             err
);

  typedef enum logic [1:0] {
    REL_UNKNOWN = 2'b00,
    REL_LOWER   = 2'b01,
    REL_EQUAL   = 2'b10,
    REL_GREATER = 2'b11
  } rel_t;

  localparam int unsigned      RUN_W      = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
  localparam logic [RUN_W-1:0] RUN_ACCEPT = RUN_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  rel_t             r_state, r_cand;
  logic [RUN_W-1:0] r_run;
  logic [CNT_W-1:0] r_lt_cnt, r_eq_cnt, r_gt_cnt;
  logic             r_err, r_change;

  logic             w_onehot, w_sample, w_malformed, w_accept;
  rel_t             w_d, w_next_state, w_next_cand;
  logic [RUN_W-1:0] w_next_run, w_run_upd;

  assign w_onehot    = (equal & ~greater & ~lower) |
                       (~equal & greater & ~lower) |
                       (~equal & ~greater & lower);
  assign w_sample    = in_valid & w_onehot;
  assign w_malformed = in_valid & ~w_onehot;

  always_comb begin
    w_d = REL_UNKNOWN;
    if (lower)        w_d = REL_LOWER;
    else if (equal)   w_d = REL_EQUAL;
    else if (greater) w_d = REL_GREATER;
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cand  = r_cand;
    w_next_run   = r_run;
    w_run_upd    = r_run;
    w_accept     = 1'b0;
    if (w_malformed) begin
      w_next_cand = REL_UNKNOWN;
      w_next_run  = '0;
    end else if (w_sample) begin
      if (w_d == r_state) begin
        w_next_cand = r_state;
        w_next_run  = '0;
      end else begin
        if (w_d == r_cand) begin
          w_run_upd = r_run + RUN_W'(1);
        end else begin
          w_next_cand = w_d;
          w_run_upd   = RUN_W'(1);
        end
        w_next_run = w_run_upd;
        // run never exceeds DEBOUNCE: it is zeroed on the accepting sample
        if (w_run_upd == RUN_ACCEPT) begin
          w_accept     = 1'b1;
          w_next_state = w_d;
          w_next_run   = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= REL_UNKNOWN;
      r_cand   <= REL_UNKNOWN;
      r_run    <= '0;
      r_change <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_cand   <= w_next_cand;
      r_run    <= w_next_run;
      r_change <= w_accept;
    end
  end

  // clear overrides both the counter increment and a same-cycle malformed sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lt_cnt <= '0;
      r_eq_cnt <= '0;
      r_gt_cnt <= '0;
      r_err    <= 1'b0;
    end else if (clear) begin
      r_lt_cnt <= '0;
      r_eq_cnt <= '0;
      r_gt_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_malformed) r_err <= 1'b1;
      if (w_accept && w_next_state == REL_LOWER && r_lt_cnt != CNT_MAX)
        r_lt_cnt <= r_lt_cnt + CNT_W'(1);
      if (w_accept && w_next_state == REL_EQUAL && r_eq_cnt != CNT_MAX)
        r_eq_cnt <= r_eq_cnt + CNT_W'(1);
      if (w_accept && w_next_state == REL_GREATER && r_gt_cnt != CNT_MAX)
        r_gt_cnt <= r_gt_cnt + CNT_W'(1);
    end
  end

  assign state  = r_state;
  assign change = r_change;
  assign lt_cnt = r_lt_cnt;
  assign eq_cnt = r_eq_cnt;
  assign gt_cnt = r_gt_cnt;
  assign err    = r_err;

endmodule

// File: tb/tb_cmp_result_filter.sv
// Scoreboard bench: expected post-accept snapshots are queued at stimulus time
// and popped by a monitor thread whenever a DUT pulses change.
module tb_cmp_result_filter;

  typedef struct packed {
    logic [1:0] st;
    logic [7:0] lt;
    logic [7:0] eq;
    logic [7:0] gt;
    logic       er;
  } exp_t;

  logic clk, rst_n;

  logic       in_valid, equal, greater, lower, clear;
  logic [1:0] state;
  logic       change, err;
  logic [7:0] lt_cnt, eq_cnt, gt_cnt;

  logic       s_in_valid, s_equal, s_greater, s_lower, s_clear;
  logic [1:0] s_state;
  logic       s_change, s_err;
  logic [1:0] s_lt_cnt, s_eq_cnt, s_gt_cnt;

  exp_t q_main[$];
  exp_t q_sat[$];
  int   checks = 0;
  int   errors = 0;

  cmp_result_filter #(.DEBOUNCE(3), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .equal(equal),
    .greater(greater), .lower(lower), .clear(clear), .state(state),
    .change(change), .lt_cnt(lt_cnt), .eq_cnt(eq_cnt), .gt_cnt(gt_cnt),
    .err(err)
  );

  cmp_result_filter #(.DEBOUNCE(1), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .equal(s_equal),
    .greater(s_greater), .lower(s_lower), .clear(s_clear), .state(s_state),
    .change(s_change), .lt_cnt(s_lt_cnt), .eq_cnt(s_eq_cnt), .gt_cnt(s_gt_cnt),
    .err(s_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic e, input logic g, input logic l, input logic c);
    in_valid = v; equal = e; greater = g; lower = l; clear = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0; equal = 1'b0; greater = 1'b0; lower = 1'b0; clear = 1'b0;
  endtask

  task automatic step_s(input logic e, input logic g);
    s_in_valid = 1'b1; s_equal = e; s_greater = g; s_lower = 1'b0;
    @(posedge clk);
    #1;
    s_in_valid = 1'b0; s_equal = 1'b0; s_greater = 1'b0;
  endtask

  task automatic push(input logic [1:0] st, input int lt, input int eq, input int gt, input logic er);
    exp_t x;
    x.st = st; x.lt = 8'(lt); x.eq = 8'(eq); x.gt = 8'(gt); x.er = er;
    q_main.push_back(x);
  endtask

  task automatic chk_quiet(input string name, input logic [1:0] st);
    chk({name, "_state"}, 32'(state), 32'(st));
    chk({name, "_change"}, 32'(change), 32'd0);
  endtask

  initial begin
    exp_t x;
    exp_t y;
    rst_n = 1'b0;
    in_valid = 0; equal = 0; greater = 0; lower = 0; clear = 0;
    s_in_valid = 0; s_equal = 0; s_greater = 0; s_lower = 0; s_clear = 0;

    fork
      forever begin
        @(negedge clk);
        if (rst_n && change) begin
          if (q_main.size() == 0) begin
            chk("main_unexpected_change", 32'd1, 32'd0);
          end else begin
            x = q_main.pop_front();
            chk("mon_state",  32'(state),  32'(x.st));
            chk("mon_lt_cnt", 32'(lt_cnt), 32'(x.lt));
            chk("mon_eq_cnt", 32'(eq_cnt), 32'(x.eq));
            chk("mon_gt_cnt", 32'(gt_cnt), 32'(x.gt));
            chk("mon_err",    32'(err),    32'(x.er));
          end
        end
        if (rst_n && s_change) begin
          if (q_sat.size() == 0) begin
            chk("sat_unexpected_change", 32'd1, 32'd0);
          end else begin
            y = q_sat.pop_front();
            chk("sat_state",  32'(s_state),  32'(y.st));
            chk("sat_eq_cnt", 32'(s_eq_cnt), 32'(y.eq));
            chk("sat_gt_cnt", 32'(s_gt_cnt), 32'(y.gt));
            chk("sat_lt_cnt", 32'(s_lt_cnt), 32'(y.lt));
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_state",  32'(state),  32'd0);
    chk("rst_change", 32'(change), 32'd0);
    chk("rst_lt",     32'(lt_cnt), 32'd0);
    chk("rst_eq",     32'(eq_cnt), 32'd0);
    chk("rst_gt",     32'(gt_cnt), 32'd0);
    chk("rst_err",    32'(err),    32'd0);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0);

    // basic accept: GT x3
    step(1, 0, 1, 0, 0); chk_quiet("basic1", 2'b00);
    step(1, 0, 1, 0, 0); chk_quiet("basic2", 2'b00);
    push(2'b11, 0, 0, 1, 0);
    step(1, 0, 1, 0, 0);
    chk("basic_state",  32'(state),  32'd3);
    chk("basic_change", 32'(change), 32'd1);
    step(0, 0, 0, 0, 0);
    chk("basic_pulse_end", 32'(change), 32'd0);

    // run break and gaps: LT,LT,GT,LT,gap,gap,LT,LT
    step(1, 0, 0, 1, 0); chk_quiet("brk1", 2'b11);
    step(1, 0, 0, 1, 0); chk_quiet("brk2", 2'b11);
    step(1, 0, 1, 0, 0); chk_quiet("brk3", 2'b11);
    step(1, 0, 0, 1, 0); chk_quiet("brk4", 2'b11);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0); chk_quiet("brk5", 2'b11);
    push(2'b01, 1, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    chk("brk_state", 32'(state), 32'd1);

    // malformed mid-run breaks the run and sets sticky err
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 1, 1, 0);
    chk("mal_err", 32'(err), 32'd1);
    step(1, 1, 0, 0, 0); chk_quiet("mal1", 2'b01);
    step(1, 1, 0, 0, 0); chk_quiet("mal2", 2'b01);
    push(2'b10, 1, 1, 1, 1);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("mal_zero_err", 32'(err), 32'd1);
    step(0, 0, 0, 0, 1);
    chk("clr_err",   32'(err),    32'd0);
    chk("clr_lt",    32'(lt_cnt), 32'd0);
    chk("clr_eq",    32'(eq_cnt), 32'd0);
    chk("clr_state", 32'(state),  32'd2);

    // malformed together with clear: err stays 0, run still broken
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    step(1, 1, 1, 0, 1);
    chk("malclr_err", 32'(err), 32'd0);
    step(1, 0, 1, 0, 0); chk_quiet("malclr1", 2'b10);
    step(1, 0, 1, 0, 0); chk_quiet("malclr2", 2'b10);
    push(2'b11, 0, 0, 1, 0);
    step(1, 0, 1, 0, 0);

    // clear on the accepting edge
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    push(2'b01, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1);
    chk("clracc_lt",     32'(lt_cnt), 32'd0);
    chk("clracc_state",  32'(state),  32'd1);
    chk("clracc_change", 32'(change), 32'd1);

    // asynchronous reset mid-run
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    push(2'b10, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 1, 0);
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_state",  32'(state),  32'd0);
    chk("arst_change", 32'(change), 32'd0);
    chk("arst_eq",     32'(eq_cnt), 32'd0);
    chk("arst_err",    32'(err),    32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1, 0, 1, 0, 0); chk_quiet("arst1", 2'b00);
    step(1, 0, 1, 0, 0); chk_quiet("arst2", 2'b00);
    push(2'b11, 0, 0, 1, 0);
    step(1, 0, 1, 0, 0);
    chk("arst_gt_state", 32'(state), 32'd3);

    // saturation, DEBOUNCE=1 CNT_W=2: EQ/GT alternating ten times
    for (int i = 0; i < 10; i++) begin
      exp_t z;
      z.st = (i % 2 == 0) ? 2'b10 : 2'b11;
      z.lt = 8'd0;
      z.eq = 8'((i / 2 + 1 > 3) ? 3 : i / 2 + 1);
      z.gt = 8'(((i + 1) / 2 > 3) ? 3 : (i + 1) / 2);
      z.er = 1'b0;
      q_sat.push_back(z);
      step_s(i % 2 == 0, i % 2 == 1);
      chk("sat_direct_state", 32'(s_state), 32'(z.st));
    end
    step_s(1'b0, 1'b1);
    chk("sat_same_change", 32'(s_change), 32'd0);
    chk("sat_final_eq",    32'(s_eq_cnt), 32'd3);
    chk("sat_final_gt",    32'(s_gt_cnt), 32'd3);

    repeat (3) @(posedge clk);
    #1;
    chk("main_queue_drained", 32'(q_main.size()), 32'd0);
    chk("sat_queue_drained",  32'(q_sat.size()),  32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
